lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/riscv_pkg.sv | 13 +
 rtl/lsu.sv | 99 +++++++++
 tb/tb_lsu.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: datapath width and load/store size codes (funct3).
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

endpackage

// File: rtl/lsu.sv
// Load/store unit: stalls the core for the duration of a data-memory access,
// steers store data and byte enables onto the bus and aligns/extends load data.
module lsu
    import riscv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             core_req_i,
    input  logic             core_we_i,
    input  logic [2:0]       core_size_i,
    input  logic [XLEN-1:0]  core_addr_i,
    input  logic [XLEN-1:0]  core_wd_i,
    output logic [XLEN-1:0]  core_rd_o,
    output logic             core_stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [BE_W-1:0]  mem_be_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wd_o,
    input  logic [XLEN-1:0]  mem_rd_i,
    input  logic             mem_ready_i
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign off = core_addr_i[1:0];

    // Stall until memory answers in WAIT; an access always costs at least one stall cycle.
    assign core_stall_o = core_req_i & ~((state == S_WAIT) & mem_ready_i);

    // State register: WAIT tracks an access whose first stall cycle has elapsed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= core_stall_o ? S_WAIT : S_IDLE;
        end
    end

    assign mem_req_o  = core_req_i;
    assign mem_we_o   = core_req_i & core_we_i;
    assign mem_addr_o = core_addr_i;

    // Byte enables from size and address; misaligned low bits are ignored.
    always_comb begin
        mem_be_o = 4'b0000;
        case (core_size_i)
            LDST_B, LDST_BU: mem_be_o = 4'(4'b0001 << off);
            LDST_H, LDST_HU: mem_be_o = off[1] ? 4'b1100 : 4'b0011;
            LDST_W:          mem_be_o = 4'b1111;
            default:         mem_be_o = 4'b0000;
        endcase
    end

    // Replicate store data so every lane carries the right-aligned value.
    always_comb begin
        mem_wd_o = core_wd_i;
        case (core_size_i)
            LDST_B:  mem_wd_o = {4{core_wd_i[7:0]}};
            LDST_H:  mem_wd_o = {2{core_wd_i[15:0]}};
            default: mem_wd_o = core_wd_i;
        endcase
    end

    // Pick the addressed byte and halfword lanes out of the raw memory word.
    always_comb begin
        ld_byte = mem_rd_i[7:0];
        case (off)
            2'd0: ld_byte = mem_rd_i[7:0];
            2'd1: ld_byte = mem_rd_i[15:8];
            2'd2: ld_byte = mem_rd_i[23:16];
            2'd3: ld_byte = mem_rd_i[31:24];
            default: ld_byte = mem_rd_i[7:0];
        endcase
        ld_half = off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    end

    // Sign- or zero-extend the selected lane; undefined sizes return zero.
    always_comb begin
        core_rd_o = '0;
        case (core_size_i)
            LDST_B:  core_rd_o = {{24{ld_byte[7]}}, ld_byte};
            LDST_BU: core_rd_o = {24'h0, ld_byte};
            LDST_H:  core_rd_o = {{16{ld_half[15]}}, ld_half};
            LDST_HU: core_rd_o = {16'h0, ld_half};
            LDST_W:  core_rd_o = mem_rd_i;
            default: core_rd_o = '0;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset corner cases, randomized accesses
// against a transaction-level reference model, and per-cycle handshake properties.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int total  = 0;
    int passed = 0;

    lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference model: lane arithmetic straight from the size/address rules.
    function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
        int o;
        o = int'(addr % 4);
        case (size)
            3'd0, 3'd4: return 4'(1 << o);
            3'd1, 3'd5: return (o >= 2) ? 4'hC : 4'h3;
            3'd2:       return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            3'd0:    return (wd % 256) * 32'h0101_0101;
            3'd1:    return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (addr % 4))) % 256;
        h = (rd >> (16 * ((addr % 4) / 2))) % 65536;
        case (size)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    // One access starting just after a rising edge: expects 1 + nwait stall cycles.
    task automatic do_access(input string name, input logic [2:0] size, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] mrd, input int nwait,
                             input logic [31:0] erd, input logic [3:0] ebe,
                             input logic [31:0] ewd, input bit idle_rand);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = $urandom;
        mem_ready_i = idle_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk_i);
        chk({name, "_stall_first"}, 32'(core_stall_o), 32'd1);
        chk({name, "_mem_req"}, 32'(mem_req_o), 32'd1);
        chk({name, "_mem_we"}, 32'(mem_we_o), 32'(we));
        chk({name, "_mem_addr"}, mem_addr_o, addr);
        chk({name, "_be"}, 32'(mem_be_o), 32'(ebe));
        if (size inside {3'd0, 3'd1, 3'd2}) chk({name, "_wd"}, mem_wd_o, ewd);
        @(posedge clk_i); #1;
        for (int k = 0; k < nwait; k++) begin
            mem_ready_i = 1'b0;
            mem_rd_i    = $urandom;
            @(negedge clk_i);
            chk({name, "_stall_wait"}, 32'(core_stall_o), 32'd1);
            @(posedge clk_i); #1;
        end
        mem_ready_i = 1'b1;
        mem_rd_i    = mrd;
        @(negedge clk_i);
        chk({name, "_stall_done"}, 32'(core_stall_o), 32'd0);
        if (!we) chk({name, "_rd"}, core_rd_o, erd);
        @(posedge clk_i); #1;
    endtask

    task automatic idle_cycle(input string name, input bit ready_rand);
        core_req_i  = 1'b0;
        mem_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk_i);
        chk({name, "_idle_stall"}, 32'(core_stall_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    // Handshake properties with ready tied high, checked every cycle while enabled.
    bit   assert_en = 1'b0;
    bit   a_valid   = 1'b0;
    bit   rose      = 1'b0;
    logic prev_stall = 1'b0;

    always @(negedge clk_i) begin
        if (assert_en && !rst_i) begin
            if (a_valid) begin
                chk("prop_req_implies_stall", 32'(mem_req_o & ~(core_stall_o | prev_stall)), 32'd0);
                if (rose) chk("prop_stall_one_cycle", 32'(core_stall_o), 32'd0);
            end
            rose       = a_valid && core_stall_o && !prev_stall;
            prev_stall = core_stall_o;
            a_valid    = 1'b1;
        end else begin
            a_valid = 1'b0;
            rose    = 1'b0;
        end
    end

    typedef struct {
        logic [2:0]  size;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          nwait;
        logic [31:0] erd;
        logic [3:0]  ebe;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{3'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{3'd0, 1'b0, 32'h13, 32'h0,        32'h80FF0000, 0, 32'hFFFFFF80, 4'h8, 32'h0};
        vecs[2]  = '{3'd4, 1'b0, 32'h13, 32'h0,        32'h80FF0000, 0, 32'h00000080, 4'h8, 32'h0};
        vecs[3]  = '{3'd1, 1'b1, 32'h22, 32'h1234ABCD, 32'h0,        0, 32'h0,        4'hC, 32'hABCDABCD};
        vecs[4]  = '{3'd2, 1'b0, 32'h40, 32'h0,        32'h12345678, 3, 32'h12345678, 4'hF, 32'h0};
        vecs[5]  = '{3'd1, 1'b0, 32'h02, 32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 4'hC, 32'h0};
        vecs[6]  = '{3'd5, 1'b0, 32'h03, 32'h0,        32'h80017FFF, 0, 32'h00008001, 4'hC, 32'h0};
        vecs[7]  = '{3'd0, 1'b1, 32'h01, 32'h000000A5, 32'h0,        0, 32'h0,        4'h2, 32'hA5A5A5A5};
        vecs[8]  = '{3'd2, 1'b1, 32'h07, 32'hCAFEF00D, 32'h0,        0, 32'h0,        4'hF, 32'hCAFEF00D};
        vecs[9]  = '{3'd3, 1'b0, 32'h08, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        4'h0, 32'h0};
        vecs[10] = '{3'd1, 1'b0, 32'h00, 32'h0,        32'h00007FFF, 0, 32'h00007FFF, 4'h3, 32'h0};
        vecs[11] = '{3'd4, 1'b0, 32'h12, 32'h0,        32'h00AB0000, 2, 32'h000000AB, 4'h4, 32'h0};

        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b1;

        // Reset state: stall follows the request, even across edges with ready high.
        @(negedge clk_i);
        chk("reset_stall_noreq", 32'(core_stall_o), 32'd0);
        core_req_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("reset_stall_req", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(posedge clk_i); #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].size, vecs[i].we, vecs[i].addr,
                      vecs[i].wd, vecs[i].mrd, vecs[i].nwait, vecs[i].erd,
                      vecs[i].ebe, vecs[i].ewd, 1'b0);
            idle_cycle($sformatf("vec%0d", i), 1'b0);
        end

        // Reset asserted mid-WAIT must return to IDLE without a clock edge.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h100;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rst_seq_stall0", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_seq_wait", 32'(core_stall_o), 32'd1);
        #1 mem_ready_i = 1'b1;
        #1 chk("rst_seq_ready_in_wait", 32'(core_stall_o), 32'd0);
        rst_i = 1'b1;
        #1 chk("rst_async_idle", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_hold_stall", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("rst_release_idle", 32'(core_stall_o), 32'd0);
        @(posedge clk_i); #1;
        do_access("post_rst", 3'd2, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 0,
                  32'h0BADF00D, 4'hF, 32'h0, 1'b0);

        // Random accesses with ready tied high and per-cycle properties enabled.
        assert_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  sz;
            logic        we;
            logic [31:0] ad, wd, rd;
            sz = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            ad = $urandom;
            wd = $urandom;
            rd = $urandom;
            do_access($sformatf("rA%0d", i), sz, we, ad, wd, rd, 0,
                      m_rd(sz, ad, rd), m_be(sz, ad), m_wd(sz, wd), 1'b0);
            if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("rA%0d", i), 1'b0);
        end
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        assert_en = 1'b0;

        // Random accesses with variable memory latency and ready noise while idle.
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  sz;
            logic        we;
            logic [31:0] ad, wd, rd;
            int          nw;
            sz = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            ad = $urandom;
            wd = $urandom;
            rd = $urandom;
            nw = $urandom_range(0, 3);
            do_access($sformatf("rB%0d", i), sz, we, ad, wd, rd, nw,
                      m_rd(sz, ad, rd), m_be(sz, ad), m_wd(sz, wd), 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                idle_cycle($sformatf("rB%0d", i), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
